pa_spsram_128x42_ctrl: RTL and testbench
========================================

PA_SPSRAM_128X42_CTRL -- requirements
Module: pa_spsram_128x42_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 forever_cpuclk  in  1  Block clock; all state updates on its rising edge.
REQ-003 cpurst  in  1  Asynchronous reset, active-high.
REQ-004 inv_req  in  1  Full-array invalidate request; sampled in IDLE only.
REQ-005 inv_done  out  1  One-cycle pulse marking the end of an INIT or INV sweep.
REQ-006 rd_vld  in  1  Read request valid.
REQ-007 rd_idx  in  7  Read index.
REQ-008 rd_rdy  out  1  Read accepted this cycle when rd_vld and rd_rdy are both high.
REQ-009 wr_vld  in  1  Write request valid.
REQ-010 wr_idx  in  7  Write index.
REQ-011 wr_data  in  42  Write data.
REQ-012 wr_hmask  in  2  Half-write enables: bit0 selects [20:0], bit1 selects [41:21], 1 = write.
REQ-013 wr_rdy  out  1  Write accepted this cycle when wr_vld and wr_rdy are both high.
REQ-014 rsp_vld  out  1  Read data valid; one-cycle pulse.
REQ-015 rsp_data  out  42  Read data.
REQ-016 sram_a  out  7  SRAM address.
REQ-017 sram_cen  out  1  SRAM chip enable, active-low.
REQ-018 sram_gwen  out  1  SRAM global write enable, active-low.
REQ-019 sram_wen  out  42  SRAM bit write enables, active-low.
REQ-020 sram_d  out  42  SRAM write data.
REQ-021 sram_q  in  42  SRAM read data; valid one cycle after a read access.

Function
REQ-022 The FSM SHALL have states INIT, IDLE and INV; after reset it is in INIT with the sweep counter at 0.
REQ-023 In INIT and INV, each cycle SHALL issue one write: sram_a = counter, sram_cen = 0, sram_gwen = 0, sram_wen = all 0, sram_d = 0.
REQ-024 The counter SHALL increment by 1 per sweep write; the write at 127 SHALL be the last, with the FSM entering IDLE and the counter returning to 0 on the next edge.
REQ-025 inv_done SHALL assert for exactly one cycle, in the first IDLE cycle after a sweep.
REQ-026 In INIT and INV, rd_rdy and wr_rdy SHALL be 0, and inv_req SHALL be ignored (not queued).
REQ-027 In IDLE, requests SHALL be prioritised inv_req > wr_vld > rd_vld.
REQ-028 When inv_req is high in IDLE, no access is issued that cycle, both rdy outputs are 0, and the FSM enters INV with the counter at 0.
REQ-029 wr_rdy SHALL be high in IDLE with inv_req low.
REQ-030 rd_rdy SHALL be high in IDLE with inv_req and wr_vld both low.
REQ-031 For an accepted write: sram_cen = 0, sram_gwen = 0, sram_a = wr_idx, sram_d = wr_data, sram_wen[20:0] = ~wr_hmask[0] replicated, sram_wen[41:21] = ~wr_hmask[1] replicated.
REQ-032 A write with wr_hmask = 00 SHALL still be accepted, with sram_gwen = 1.
REQ-033 For an accepted read: sram_cen = 0, sram_gwen = 1, sram_wen = all 1, sram_a = rd_idx.
REQ-034 rsp_vld SHALL pulse in the cycle after a read accept, with rsp_data = sram_q in that cycle.
REQ-035 rsp_data SHALL be captured into a 42-bit hold register on rsp_vld and driven from that register until the next rsp_vld.
REQ-036 With no access issued, sram_cen = 1, sram_gwen = 1, sram_wen = all 1, and sram_a and sram_d hold their last values.
REQ-037 A write to X in cycle N followed by a read of X in cycle N+1 SHALL return the new data at N+2.
REQ-038 Back-to-back reads SHALL sustain one accept per cycle.

Reset
REQ-039 On cpurst: state = INIT, counter = 0, inv_done = 0, rsp_vld = 0, rsp_data hold = 0, sram_cen = 1, sram_gwen = 1, sram_wen = all 1, sram_a = 0, sram_d = 0.
REQ-040 cpurst asserted mid-sweep or mid-read SHALL abandon the operation; the sweep restarts from 0, and no rsp_vld is produced for the in-flight read.

Structure
REQ-041 Constants IDX_WIDTH = 7, DATA_WIDTH = 42, HALF_WIDTH = 21 and the FSM state encodings SHALL live in a shared package.
REQ-042 The block SHALL be flat logic except for one natural sub-module, pa_spsram_sweep_cnt (7-bit counter with a last flag).

Verification
REQ-043 Release reset and idle inputs -> exactly 128 zero-writes on consecutive cycles at addresses 0..127, then inv_done high for 1 cycle, then rd_rdy = 1.
REQ-044 In IDLE, write idx 5, data 0x2AAAAAAAAAA, hmask 11; read idx 5 on the next cycle -> rsp_vld 2 cycles after the write, with rsp_data = 0x2AAAAAAAAAA.
REQ-045 Write idx 9 with all-ones data and hmask 01 after an invalidate -> a read of idx 9 returns 0x000001FFFFF.
REQ-046 Assert inv_req, wr_vld and rd_vld together in IDLE -> both rdy outputs 0, INV sweep of 128 cycles, inv_done pulse, then the write is accepted before the read.
REQ-047 Assert cpurst at sweep count 60 -> after release the sweep restarts at address 0 and takes a full 128 writes.
REQ-048 Issue 4 back-to-back reads of idx 0..3 -> 4 consecutive rsp_vld pulses with in-order data, and rsp_data holds the last value afterwards.

Source files
------------

// File: rtl/pa_spsram_128x42_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pa_spsram_128x42_ctrl_pkg
// Shared constants, FSM state encoding and a small helper for the 128x42
// single-port SRAM controller.
// ----------------------------------------------------------------------------
package pa_spsram_128x42_ctrl_pkg;

    localparam int IDX_WIDTH  = 7;
    localparam int DATA_WIDTH = 42;
    localparam int HALF_WIDTH = 21;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_INV  = 2'd2
    } state_t;

    // Expand the two half-write enables (1 = write) into the SRAM's
    // active-low per-bit write enables.
    function automatic logic [DATA_WIDTH-1:0] half_wen(input logic [1:0] hmask);
        return {{HALF_WIDTH{~hmask[1]}}, {HALF_WIDTH{~hmask[0]}}};
    endfunction

endpackage

// File: rtl/pa_spsram_128x42_ctrl_if.sv
// ----------------------------------------------------------------------------
// pa_spsram_128x42_ctrl_if
// Request/response bus of the SRAM controller.
//   inv_req / inv_done             : full-array invalidate request / sweep done
//   rd_vld, rd_idx / rd_rdy        : read request handshake
//   wr_vld, wr_idx, wr_data,
//   wr_hmask / wr_rdy              : write request handshake (half-word mask)
//   rsp_vld, rsp_data              : read response
// master = requester, slave = controller.
// ----------------------------------------------------------------------------
interface pa_spsram_128x42_ctrl_if;
    import pa_spsram_128x42_ctrl_pkg::*;

    logic                  inv_req;
    logic                  inv_done;
    logic                  rd_vld;
    logic [IDX_WIDTH-1:0]  rd_idx;
    logic                  rd_rdy;
    logic                  wr_vld;
    logic [IDX_WIDTH-1:0]  wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [1:0]            wr_hmask;
    logic                  wr_rdy;
    logic                  rsp_vld;
    logic [DATA_WIDTH-1:0] rsp_data;

    modport master (
        output inv_req, rd_vld, rd_idx, wr_vld, wr_idx, wr_data, wr_hmask,
        input  inv_done, rd_rdy, wr_rdy, rsp_vld, rsp_data
    );

    modport slave (
        input  inv_req, rd_vld, rd_idx, wr_vld, wr_idx, wr_data, wr_hmask,
        output inv_done, rd_rdy, wr_rdy, rsp_vld, rsp_data
    );

endinterface

// File: rtl/pa_spsram_128x42_ctrl_sweep_cnt.sv
// ----------------------------------------------------------------------------
// pa_spsram_sweep_cnt
// 7-bit sweep address counter with a flag marking the final entry.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear to 0 (wins over inc)
//   inc      : advance by one; wraps from the last entry back to 0
//   cnt      : current sweep address
//   last     : cnt is the final array entry
// ----------------------------------------------------------------------------
module pa_spsram_sweep_cnt
    import pa_spsram_128x42_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 inc,
    output logic [IDX_WIDTH-1:0] cnt,
    output logic                 last
);

    // Counter register; the natural 7-bit wrap returns it to 0 after the
    // last sweep write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + IDX_WIDTH'(1);
        end
    end

    assign last = &cnt;

endmodule

// File: rtl/pa_spsram_128x42_ctrl.sv
// ----------------------------------------------------------------------------
// pa_spsram_128x42_ctrl
// Controller for a 128x42 single-port SRAM. After reset it zero-fills the
// array (INIT), then serves one write or one read per cycle (IDLE), and on
// inv_req zero-fills the array again (INV).
//   forever_cpuclk, cpurst : clock, asynchronous active-high reset
//   bus (slave)            : request/response bus, see the interface file
//   sram_a/cen/gwen/wen/d  : SRAM address, chip enable, global and bit
//                            write enables (active-low), write data
//   sram_q                 : SRAM read data, valid the cycle after a read
// SRAM controls are combinational from the current state and request so a
// read accepted in cycle N returns data in cycle N+1.
// ----------------------------------------------------------------------------
module pa_spsram_128x42_ctrl
    import pa_spsram_128x42_ctrl_pkg::*;
(
    input  logic                    forever_cpuclk,
    input  logic                    cpurst,
    pa_spsram_128x42_ctrl_if.slave  bus,
    output logic [IDX_WIDTH-1:0]    sram_a,
    output logic                    sram_cen,
    output logic                    sram_gwen,
    output logic [DATA_WIDTH-1:0]   sram_wen,
    output logic [DATA_WIDTH-1:0]   sram_d,
    input  logic [DATA_WIDTH-1:0]   sram_q
);

    state_t                state;
    logic [IDX_WIDTH-1:0]  cnt;
    logic                  cnt_last;
    logic                  sweeping;
    logic                  in_idle;
    logic                  wr_rdy;
    logic                  rd_rdy;
    logic                  wr_go;
    logic                  rd_go;
    logic                  inv_done;
    logic                  rsp_vld;
    logic [DATA_WIDTH-1:0] rsp_hold;
    logic [IDX_WIDTH-1:0]  a_hold;
    logic [DATA_WIDTH-1:0] d_hold;

    assign sweeping = (state == ST_INIT) || (state == ST_INV);
    assign in_idle  = (state == ST_IDLE);

    // Priority inv_req > write > read is expressed purely through the
    // ready terms.
    assign wr_rdy = in_idle && !bus.inv_req;
    assign rd_rdy = in_idle && !bus.inv_req && !bus.wr_vld;
    assign wr_go  = bus.wr_vld && wr_rdy;
    assign rd_go  = bus.rd_vld && rd_rdy;

    pa_spsram_sweep_cnt u_sweep_cnt (
        .clk  (forever_cpuclk),
        .rst  (cpurst),
        .clr  (in_idle),
        .inc  (sweeping),
        .cnt  (cnt),
        .last (cnt_last)
    );

    // SRAM pin drive. While reset is held the state already reads INIT, so
    // reset is gated in here to keep the array deselected until release.
    // Address and data hold their last driven values when no access is made.
    always_comb begin
        sram_a    = a_hold;
        sram_d    = d_hold;
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        if (!cpurst) begin
            if (sweeping) begin
                sram_a    = cnt;
                sram_d    = '0;
                sram_cen  = 1'b0;
                sram_gwen = 1'b0;
                sram_wen  = '0;
            end else if (wr_go) begin
                sram_a    = bus.wr_idx;
                sram_d    = bus.wr_data;
                sram_cen  = 1'b0;
                sram_gwen = ~|bus.wr_hmask;
                sram_wen  = half_wen(bus.wr_hmask);
            end else if (rd_go) begin
                sram_a    = bus.rd_idx;
                sram_cen  = 1'b0;
            end
        end
    end

    // State machine plus its registered outputs: the sweep-done pulse, the
    // read-response strobe, the response hold register and the remembered
    // address/data used when the SRAM is idle.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state    <= ST_INIT;
            inv_done <= 1'b0;
            rsp_vld  <= 1'b0;
            rsp_hold <= '0;
            a_hold   <= '0;
            d_hold   <= '0;
        end else begin
            inv_done <= 1'b0;
            rsp_vld  <= rd_go;
            a_hold   <= sram_a;
            d_hold   <= sram_d;
            if (rsp_vld) begin
                rsp_hold <= sram_q;
            end
            case (state)
                ST_INIT, ST_INV: begin
                    if (cnt_last) begin
                        state    <= ST_IDLE;
                        inv_done <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (bus.inv_req) begin
                        state <= ST_INV;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    assign bus.wr_rdy   = wr_rdy;
    assign bus.rd_rdy   = rd_rdy;
    assign bus.inv_done = inv_done;
    assign bus.rsp_vld  = rsp_vld;
    // Fresh SRAM data in the response cycle, held copy afterwards.
    assign bus.rsp_data = rsp_vld ? sram_q : rsp_hold;

endmodule

// File: tb/tb_pa_spsram_128x42_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pa_spsram_128x42_ctrl
// Directed self-checking bench for pa_spsram_128x42_ctrl with a behavioural
// 128x42 single-port SRAM (active-low enables, one-cycle read latency).
// Inputs change on the falling clock edge; outputs are sampled 1 time unit
// later, away from the rising edge.
// ----------------------------------------------------------------------------
module tb_pa_spsram_128x42_ctrl;
    import pa_spsram_128x42_ctrl_pkg::*;

    logic                  forever_cpuclk = 1'b0;
    logic                  cpurst;
    logic [IDX_WIDTH-1:0]  sram_a;
    logic                  sram_cen;
    logic                  sram_gwen;
    logic [DATA_WIDTH-1:0] sram_wen;
    logic [DATA_WIDTH-1:0] sram_d;
    logic [DATA_WIDTH-1:0] sram_q;
    logic [DATA_WIDTH-1:0] mem [0:127];

    int checks = 0;
    int errors = 0;

    localparam logic [DATA_WIDTH-1:0] ONES = 42'h3FFFFFFFFFF;

    pa_spsram_128x42_ctrl_if bus ();

    pa_spsram_128x42_ctrl dut (
        .forever_cpuclk (forever_cpuclk),
        .cpurst         (cpurst),
        .bus            (bus),
        .sram_a         (sram_a),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_d         (sram_d),
        .sram_q         (sram_q)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    // Behavioural SRAM: bit write where wen is low, read data one cycle later.
    always @(posedge forever_cpuclk) begin
        if (!sram_cen) begin
            if (!sram_gwen) begin
                mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            end else begin
                sram_q <= mem[sram_a];
            end
        end
    end

    task automatic check_output(input string tag, input logic [127:0] obs,
                                input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_pins(input string tag, input logic [6:0] a,
                              input logic cen, input logic gwen,
                              input logic [41:0] wen, input logic [41:0] d);
        check_output(tag, 128'({sram_a, sram_cen, sram_gwen, sram_wen, sram_d}),
                     128'({a, cen, gwen, wen, d}));
    endtask

    task automatic check_rdy(input string tag, input logic rd, input logic wr);
        check_output(tag, 128'({bus.rd_rdy, bus.wr_rdy}), 128'({rd, wr}));
    endtask

    task automatic check_rsp(input string tag, input logic vld, input logic [41:0] data);
        check_output(tag, 128'({bus.rsp_vld, bus.rsp_data}), 128'({vld, data}));
    endtask

    // Follow a zero-fill sweep from its first write; called on a falling
    // edge. poke_at raises inv_req for one cycle mid-sweep; abort_at asserts
    // reset right after that sweep write has been checked.
    task automatic run_sweep(input string tag, input int poke_at, input int abort_at);
        for (int i = 0; i < 128; i++) begin
            #1;
            check_pins({tag, "_pins"}, 7'(i), 1'b0, 1'b0, '0, '0);
            check_rdy({tag, "_rdy"}, 1'b0, 1'b0);
            bus.inv_req = (i == poke_at);
            if (i == abort_at) begin
                #2 cpurst = 1'b1;
                #1;
                check_pins({tag, "_reset_pins"}, 7'd0, 1'b1, 1'b1, ONES, '0);
                check_rdy({tag, "_reset_rdy"}, 1'b0, 1'b0);
                return;
            end
            @(negedge forever_cpuclk);
        end
        #1;
        check_output({tag, "_inv_done"}, 128'(bus.inv_done), 128'(1'b1));
    endtask

    // Set both request channels in one call.
    task automatic apply_stimulus(input logic inv, input logic wv, input logic [6:0] widx,
                                  input logic [41:0] wdat, input logic [1:0] wm,
                                  input logic rv, input logic [6:0] ridx);
        bus.inv_req  = inv;
        bus.wr_vld   = wv;
        bus.wr_idx   = widx;
        bus.wr_data  = wdat;
        bus.wr_hmask = wm;
        bus.rd_vld   = rv;
        bus.rd_idx   = ridx;
    endtask

    logic [41:0] wdat [4];
    logic [1:0]  wmsk [4];
    logic [41:0] rexp [4];

    initial begin
        wdat[0] = 42'h123456789AB; wmsk[0] = 2'b11; rexp[0] = 42'h123456789AB;
        wdat[1] = 42'h0ABCDEF0123; wmsk[1] = 2'b11; rexp[1] = 42'h0ABCDEF0123;
        wdat[2] = 42'h3FFFFFFFFFF; wmsk[2] = 2'b10; rexp[2] = 42'h3FFFFE00000;
        wdat[3] = 42'h15555555555; wmsk[3] = 2'b11; rexp[3] = 42'h15555555555;

        cpurst = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);

        // Reset values.
        @(negedge forever_cpuclk); #1;
        check_pins("reset_pins", 7'd0, 1'b1, 1'b1, ONES, '0);
        check_rdy("reset_rdy", 1'b0, 1'b0);
        check_output("reset_inv_done", 128'(bus.inv_done), 128'(1'b0));
        check_rsp("reset_rsp", 1'b0, '0);

        // Power-up zero-fill: 128 writes, done pulse, then ready.
        @(negedge forever_cpuclk); cpurst = 1'b0;
        run_sweep("init", -1, -1);
        check_rdy("init_idle_rdy", 1'b1, 1'b1);
        check_pins("init_idle_pins", 7'd127, 1'b1, 1'b1, ONES, '0);
        @(negedge forever_cpuclk); #1;
        check_output("init_done_pulse", 128'(bus.inv_done), 128'(1'b0));

        // Full writes, write-then-read forwarding, empty-mask write.
        @(negedge forever_cpuclk); apply_stimulus(0, 1, 9, ONES, 2'b11, 0, 0); #1;
        check_pins("wr9_pins", 7'd9, 1'b0, 1'b0, '0, ONES);
        @(negedge forever_cpuclk); apply_stimulus(0, 1, 5, 42'h2AAAAAAAAAA, 2'b11, 0, 0); #1;
        check_rdy("wr5_rdy", 1'b0, 1'b1);
        check_pins("wr5_pins", 7'd5, 1'b0, 1'b0, '0, 42'h2AAAAAAAAAA);
        @(negedge forever_cpuclk); apply_stimulus(0, 0, 0, 0, 0, 1, 5); #1;
        check_rdy("rd5_rdy", 1'b1, 1'b1);
        check_pins("rd5_pins", 7'd5, 1'b0, 1'b1, ONES, 42'h2AAAAAAAAAA);
        @(negedge forever_cpuclk); apply_stimulus(0, 1, 5, 0, 2'b00, 0, 0); #1;
        check_rsp("rd5_rsp", 1'b1, 42'h2AAAAAAAAAA);
        check_rdy("wr5_nomask_rdy", 1'b0, 1'b1);
        check_pins("wr5_nomask_pins", 7'd5, 1'b0, 1'b1, ONES, '0);
        @(negedge forever_cpuclk); apply_stimulus(0, 0, 0, 0, 0, 1, 5); #1;
        check_rsp("rsp_hold_after_pulse", 1'b0, 42'h2AAAAAAAAAA);
        @(negedge forever_cpuclk); apply_stimulus(0, 0, 0, 0, 0, 0, 0); #1;
        check_rsp("rd5_after_nomask", 1'b1, 42'h2AAAAAAAAAA);
        check_pins("idle_hold_pins", 7'd5, 1'b1, 1'b1, ONES, '0);

        // inv_req + write + read together: invalidate first, write, read.
        @(negedge forever_cpuclk); apply_stimulus(1, 1, 9, ONES, 2'b01, 1, 9); #1;
        check_rdy("inv_req_rdy", 1'b0, 1'b0);
        check_pins("inv_req_pins", 7'd5, 1'b1, 1'b1, ONES, '0);
        @(negedge forever_cpuclk); bus.inv_req = 1'b0;
        run_sweep("inv", 64, -1);
        check_rdy("inv_idle_rdy", 1'b0, 1'b1);
        check_pins("wr9_half_pins", 7'd9, 1'b0, 1'b0, 42'h3FFFFE00000, ONES);
        @(negedge forever_cpuclk); bus.wr_vld = 1'b0; #1;
        check_rdy("rd9_rdy", 1'b1, 1'b1);
        check_pins("rd9_pins", 7'd9, 1'b0, 1'b1, ONES, ONES);
        @(negedge forever_cpuclk); bus.rd_vld = 1'b0; #1;
        check_rsp("rd9_rsp", 1'b1, 42'h000001FFFFF);
        check_pins("no_requeued_inv", 7'd9, 1'b1, 1'b1, ONES, ONES);

        // Back-to-back writes then back-to-back reads of idx 0..3.
        for (int k = 0; k < 4; k++) begin
            @(negedge forever_cpuclk); apply_stimulus(0, 1, 7'(k), wdat[k], wmsk[k], 0, 0); #1;
            check_rdy("b2b_wr_rdy", 1'b0, 1'b1);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge forever_cpuclk); apply_stimulus(0, 0, 0, 0, 0, 1, 7'(k)); #1;
            check_rdy("b2b_rd_rdy", 1'b1, 1'b1);
            if (k > 0) check_rsp("b2b_rsp", 1'b1, rexp[k-1]);
            else check_output("b2b_first_no_rsp", 128'(bus.rsp_vld), 128'(1'b0));
        end
        @(negedge forever_cpuclk); bus.rd_vld = 1'b0; #1;
        check_rsp("b2b_rsp_last", 1'b1, rexp[3]);
        @(negedge forever_cpuclk); #1;
        check_rsp("b2b_rsp_hold", 1'b0, rexp[3]);

        // Reset during a read: no response, hold register cleared.
        @(negedge forever_cpuclk); bus.rd_vld = 1'b1; bus.rd_idx = 7'd3; #1;
        check_rdy("rd_abort_rdy", 1'b1, 1'b1);
        #1 cpurst = 1'b1;
        #1 bus.rd_vld = 1'b0;
        @(negedge forever_cpuclk); #1;
        check_rsp("rd_abort_rsp", 1'b0, '0);
        check_pins("rd_abort_pins", 7'd0, 1'b1, 1'b1, ONES, '0);
        @(negedge forever_cpuclk); cpurst = 1'b0;
        run_sweep("init2", -1, -1);

        // Reset at sweep count 60, then a complete restart from address 0.
        @(negedge forever_cpuclk); bus.inv_req = 1'b1; #1;
        check_rdy("inv2_req_rdy", 1'b0, 1'b0);
        @(negedge forever_cpuclk); bus.inv_req = 1'b0;
        run_sweep("inv_abort", -1, 60);
        @(negedge forever_cpuclk); cpurst = 1'b0;
        run_sweep("init3", -1, -1);
        check_rdy("init3_idle_rdy", 1'b1, 1'b1);

        // The fill reached the array: idx 3 now reads back zero.
        @(negedge forever_cpuclk); apply_stimulus(0, 0, 0, 0, 0, 1, 3);
        @(negedge forever_cpuclk); bus.rd_vld = 1'b0; #1;
        check_rsp("rd3_after_fill", 1'b1, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
